vga_frame_receiver: RTL

//  Receive side of the VGA output link: samples RGBA/h_sync/v_sync as driven by the rasteriser top.

---
 rtl/vga_frame_receiver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_receiver.sv
// vga_frame_receiver: receive side of the VGA link.
// Samples RGBA/h_sync/v_sync once, locks to the sync timing, rebuilds pixel
// coordinates and emits a visible-pixel stream with frame markers. Timing
// violations are flagged with sync_err and drop lock.
// Optional feature macro: FRAME_CRC_EN (CRC-16-CCITT over each complete frame);
// when undefined frame_crc is tied to zero.
//
// state  | meaning
// SEARCH | waiting for a v_sync leading edge
// ALIGN  | v edge seen, waiting for the first h_sync leading edge
// LOCKED | counters track the source; edges are checked against the wraps
module vga_frame_receiver #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        Mreset,
  input  logic [11:0] RGBA,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic        pix_valid,
  output logic [9:0]  px,
  output logic [8:0]  py,
  output logic [11:0] pix_rgba,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_crc
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VS   = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] H_VE   = HCW'(H_SYNC + H_BP + H_VIS - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VS   = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] V_VE   = VCW'(V_SYNC + V_BP + V_VIS - 1);
  localparam logic [9:0]     PX_LAST = 10'(H_VIS - 1);
  localparam logic [8:0]     PY_LAST = 9'(V_VIS - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [HCW-1:0]  hcnt_q, hcnt_d, cur_h;
  logic [VCW-1:0]  vcnt_q, vcnt_d, cur_v;
  logic [11:0]     rgba_q;
  logic            h_act_q, v_act_q, h_prev_q, v_prev_q;
  logic            h_edge, v_edge, h_wrap, v_wrap;
  logic            err, tracking, frame_roll, armed_q, armed_now;
  logic            pv_d;
  logic [9:0]      px_d;
  logic [8:0]      py_d;

  // Input stage: register the link once, store sync as "asserted" level.
  always_ff @(posedge clk or posedge Mreset) begin
    if (Mreset) begin
      rgba_q   <= '0;
      h_act_q  <= 1'b0;
      v_act_q  <= 1'b0;
      h_prev_q <= 1'b0;
      v_prev_q <= 1'b0;
    end else begin
      rgba_q   <= RGBA;
      h_act_q  <= h_sync ^ SYNC_LOW;
      v_act_q  <= v_sync ^ SYNC_LOW;
      h_prev_q <= h_act_q;
      v_prev_q <= v_act_q;
    end
  end

  assign h_edge = h_act_q & ~h_prev_q;
  assign v_edge = v_act_q & ~v_prev_q;

  // Next state, position of the sample in the input stage, and timing checks.
  // The counters hold the position of the previous sample, so the current
  // position is their increment.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    cur_h      = '0;
    cur_v      = '0;
    err        = 1'b0;
    tracking   = 1'b0;
    frame_roll = 1'b0;
    h_wrap     = (hcnt_q == H_LAST);
    v_wrap     = h_wrap && (vcnt_q == V_LAST);
    case (state_q)
      SEARCH: begin
        // A v edge that coincides with an h edge is also the first h edge.
        if (v_edge && h_edge) begin
          state_d = LOCKED;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else if (v_edge) begin
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (h_edge) begin
          state_d = LOCKED;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      end
      LOCKED: begin
        cur_h = h_wrap ? '0 : hcnt_q + 1'b1;
        cur_v = h_wrap ? ((vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1) : vcnt_q;
        if ((h_edge != h_wrap) || (v_edge != v_wrap)) begin
          err     = 1'b1;
          state_d = SEARCH;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else begin
          tracking   = 1'b1;
          hcnt_d     = cur_h;
          vcnt_d     = cur_v;
          frame_roll = v_wrap;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // A frame is only reported once a full frame has been tracked since lock.
  always_comb begin
    armed_now = armed_q | frame_roll;
    pv_d      = tracking && armed_now &&
                (cur_h >= H_VS) && (cur_h <= H_VE) &&
                (cur_v >= V_VS) && (cur_v <= V_VE);
    px_d      = 10'(cur_h) - 10'(H_VS);
    py_d      = 9'(cur_v) - 9'(V_VS);
  end

  // State, counters and registered pixel/status outputs.
  always_ff @(posedge clk or posedge Mreset) begin
    if (Mreset) begin
      state_q     <= SEARCH;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      armed_q     <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      pix_valid   <= 1'b0;
      px          <= '0;
      py          <= '0;
      pix_rgba    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      armed_q     <= (state_d == LOCKED) && armed_now;
      locked      <= (state_d == LOCKED);
      sync_err    <= err;
      pix_valid   <= pv_d;
      px          <= pv_d ? px_d : '0;
      py          <= pv_d ? py_d : '0;
      pix_rgba    <= pv_d ? rgba_q : '0;
      frame_start <= pv_d && (px_d == '0) && (py_d == '0);
      frame_done  <= pv_d && (px_d == PX_LAST) && (py_d == PY_LAST);
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc_q, crc_next;

  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_next = crc12(frame_start ? 16'hFFFF : crc_q, pix_rgba);

  // Running CRC over the output stream; the result is kept only for frames
  // that reach frame_done.
  always_ff @(posedge clk or posedge Mreset) begin
    if (Mreset) begin
      crc_q     <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (pix_valid) begin
      crc_q <= crc_next;
      if (frame_done) frame_crc <= crc_next;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
